csr_file: RTL and testbench
===========================

# csr_file

Control/status register file for the LoongArch pipeline; it is the consumer of the writeback stage's register-file and CSR buses. It serves combinational CSR reads to decode and retires CSR writes, exceptions and ERTN at writeback. It also runs the stable timer and generates the pipeline flush request (`ex_en`), the redirect target and the interrupt-pending flag.

## Interface
Parameters:
- `TIMER_W`, 32, timer counter width (fixed 32; parameter exists for documentation only).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `Wcsr_BUS`  in  153  from writeback, MSB first: `ex`(1), `ecode`(8), `esubcode`(1), `csr_we`(1), `csr_addr`(14), `csr_wmask`(32), `csr_wdata`(32), `pc`(32), `vaddr`(32). `ex` and `csr_we` arrive pre-qualified by the writeback valid bit.
- `ertn_W`  in  1  valid ERTN retiring in writeback.
- `hw_int`  in  8  level hardware interrupt lines.
- `csr_raddr`  in  14  read address from decode.
- `csr_rdata`  out  32  combinational read data.
- `ex_en`  out  1  flush request to all stages = `ex | ertn_W`.
- `ex_entry`  out  32  redirect PC: EENTRY when `ex`, ERA when `ertn_W` only.
- `has_int`  out  1  interrupt pending and enabled.

## Operation
- Implemented CSRs and their writable fields. All unlisted bits read 0.
  - CRMD 0x00: PLV[1:0], IE[2], DA[3]; reset 0x0000_0008.
  - PRMD 0x01: PPLV[1:0], PIE[2].
  - ECFG 0x04: LIE[9:0], LIE[12:11]; bit 10 is RO 0.
  - ESTAT 0x05: IS[1:0] is SW-writable. The following are not CSR-writable: IS[9:2] (= `hw_int` registered every cycle), IS[11] (timer), Ecode[21:16], EsubCode[30:22].
  - ERA 0x06, BADV 0x07, SAVE0–3 0x30–0x33, TID 0x40: full 32 bits.
  - EENTRY 0x0C: VA[31:6].
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: RO.
  - TICLR 0x44: write-1-to-clear on bit 0; reads 0.
- Every register resets to 0 except CRMD.
- CSR write when `csr_we && !ex`: `new = (old & ~wmask) | (wdata & wmask)`, restricted to writable bits. Writes to unimplemented addresses are dropped.
- Exception when `ex=1`, in one cycle:
  - PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE; CRMD.PLV<=0; CRMD.IE<=0.
  - ESTAT.Ecode<=ecode[5:0]; ESTAT.EsubCode<={8'b0,esubcode}; ERA<=pc.
  - BADV<=vaddr only when ecode is 0x08 (ADE) or 0x09 (ALE).
  - The CSR write carried on the same bus is ignored.
- ERTN when `ertn_W=1` and `ex=0`: CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
- `ex` and `ertn_W` both high: the exception wins and `ex_entry`=EENTRY.
- Timer:
  - A TCFG write with new En=1 loads TVAL<={InitVal,2'b00}. The timer does not count that cycle.
  - Otherwise, if En=1 and TVAL≠0: TVAL decrements by 1.
  - If En=1 and TVAL=0: IS[11]<=1. If Periodic=1, TVAL reloads {InitVal,2'b00}; if Periodic=0, En<=0 and TVAL holds 0.
  - A TICLR write with bit0=1 clears IS[11]. A timer fire in the same cycle wins (IS[11] stays 1).
- `has_int = CRMD.IE && |(ESTAT.IS[12:0] & ECFG.LIE[12:0])`.
- Reads return registered values; there is no write-to-read bypass. Decode resolves CSR hazards.

## Timing
- `csr_rdata`, `ex_en`, `ex_entry` and `has_int` are combinational. `ex_en` asserts in the same cycle as `ex`/`ertn_W`. Writeback drops its valid on the next edge.
- All register updates become visible on `csr_rdata` one cycle after the retiring cycle.
- `hw_int` reaches `has_int` with 1-cycle latency.
- Output values during reset: `ex_en`/`ex_entry` follow their inputs; `has_int`=0; `csr_rdata` reads the reset values.
- Asynchronous reset mid-countdown clears TVAL, TCFG and IS[11] immediately.

## Test plan
- Reset, then read 0x00 -> 0x8. Read 0x05 -> 0. `has_int`=0.
- Write CRMD wdata 0x7, mask 0x4 -> CRMD reads 0xC.
  - Then exception with ecode 0x09, pc 0x1C00_0100, vaddr 0x1234_5677, EENTRY=0x1C00_8000 -> same cycle `ex_en`=1 and `ex_entry`=0x1C00_8000.
  - Next cycle: ERA=0x1C00_0100, BADV=0x1234_5677, ESTAT[21:16]=0x09, PRMD=0x4, CRMD=0x8.
- Following the previous case, `ertn_W`=1 -> `ex_entry`=0x1C00_0100 and CRMD.IE=1 next cycle.
- TCFG write 0x13 (InitVal 4, periodic, En) -> TVAL reads 0x10, counts to 0, and IS[11] sets 17 cycles after the write edge.
  - TVAL reloads 0x10. With CRMD.IE=1 and LIE[11]=1, `has_int`=1.
  - TICLR write 1 -> IS[11]=0 next cycle.
- Simultaneous `ex` and `csr_we` to SAVE0 -> SAVE0 unchanged.
  - Simultaneous timer fire and TICLR write -> IS[11]=1.
- Assert `rstn` low mid-count -> TVAL=0 and TCFG=0 without a clock edge.

Source files
------------

// File: rtl/csr_file.sv
// LoongArch CSR file: combinational reads for decode, writeback-retired writes/exceptions/ERTN, stable timer.
// Register updates are visible one cycle after retire; ex_en/ex_entry/has_int are combinational, no backpressure.
module csr_file #(
   parameter int TIMER_W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [152:0] Wcsr_BUS,
   input  logic         ertn_W,
   input  logic [7:0]   hw_int,
   input  logic [13:0]  csr_raddr,
   output logic [31:0]  csr_rdata,
   output logic         ex_en,
   output logic [31:0]  ex_entry,
   output logic         has_int
);

   localparam logic [13:0] A_CRMD   = 14'h00;
   localparam logic [13:0] A_PRMD   = 14'h01;
   localparam logic [13:0] A_ECFG   = 14'h04;
   localparam logic [13:0] A_ESTAT  = 14'h05;
   localparam logic [13:0] A_ERA    = 14'h06;
   localparam logic [13:0] A_BADV   = 14'h07;
   localparam logic [13:0] A_EENTRY = 14'h0C;
   localparam logic [13:0] A_SAVE0  = 14'h30;
   localparam logic [13:0] A_SAVE1  = 14'h31;
   localparam logic [13:0] A_SAVE2  = 14'h32;
   localparam logic [13:0] A_SAVE3  = 14'h33;
   localparam logic [13:0] A_TID    = 14'h40;
   localparam logic [13:0] A_TCFG   = 14'h41;
   localparam logic [13:0] A_TVAL   = 14'h42;
   localparam logic [13:0] A_TICLR  = 14'h44;

   logic        w_ex, w_esub, w_we, w_wr;
   logic [7:0]  w_ecode;
   logic [13:0] w_addr;
   logic [31:0] w_wmask, w_wdata, w_pc, w_vaddr;
   logic [31:0] w_wk, w_wd, w_tcfg_nv;
   logic [31:0] w_crmd, w_prmd, w_ecfg, w_estat, w_eentry;

   logic [1:0]         r_crmd_plv;
   logic               r_crmd_ie, r_crmd_da;
   logic [1:0]         r_prmd_pplv;
   logic               r_prmd_pie;
   logic [12:0]        r_ecfg_lie;
   logic [1:0]         r_estat_is_sw;
   logic [7:0]         r_estat_is_hw;
   logic               r_estat_ti;
   logic [5:0]         r_estat_ecode;
   logic [8:0]         r_estat_esub;
   logic [31:0]        r_era, r_badv, r_tid, r_tcfg;
   logic [25:0]        r_eentry_va;
   logic [31:0]        r_save [4];
   logic [TIMER_W-1:0] r_tval;

   assign {w_ex, w_ecode, w_esub, w_we, w_addr, w_wmask, w_wdata, w_pc, w_vaddr} = Wcsr_BUS;

   // A write riding alongside an exception is discarded.
   assign w_wr      = w_we & ~w_ex;
   assign w_wk      = ~w_wmask;
   assign w_wd      = w_wdata & w_wmask;
   assign w_tcfg_nv = (r_tcfg & w_wk) | w_wd;

   assign w_crmd   = {28'b0, r_crmd_da, r_crmd_ie, r_crmd_plv};
   assign w_prmd   = {29'b0, r_prmd_pie, r_prmd_pplv};
   assign w_ecfg   = {19'b0, r_ecfg_lie};
   assign w_estat  = {1'b0, r_estat_esub, r_estat_ecode, 4'b0, r_estat_ti, 1'b0, r_estat_is_hw, r_estat_is_sw};
   assign w_eentry = {r_eentry_va, 6'b0};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_crmd_plv    <= '0;
         r_crmd_ie     <= 1'b0;
         r_crmd_da     <= 1'b1;
         r_prmd_pplv   <= '0;
         r_prmd_pie    <= 1'b0;
         r_ecfg_lie    <= '0;
         r_estat_is_sw <= '0;
         r_estat_is_hw <= '0;
         r_estat_ti    <= 1'b0;
         r_estat_ecode <= '0;
         r_estat_esub  <= '0;
         r_era         <= '0;
         r_badv        <= '0;
         r_tid         <= '0;
         r_tcfg        <= '0;
         r_eentry_va   <= '0;
         r_tval        <= '0;
         for (int i = 0; i < 4; i++) r_save[i] <= '0;
      end else begin
         r_estat_is_hw <= hw_int;
         if (w_wr) begin
            case (w_addr)
               A_CRMD:   {r_crmd_da, r_crmd_ie, r_crmd_plv} <= ({r_crmd_da, r_crmd_ie, r_crmd_plv} & w_wk[3:0]) | w_wd[3:0];
               A_PRMD:   {r_prmd_pie, r_prmd_pplv} <= ({r_prmd_pie, r_prmd_pplv} & w_wk[2:0]) | w_wd[2:0];
               A_ECFG:   r_ecfg_lie <= ((r_ecfg_lie & w_wk[12:0]) | w_wd[12:0]) & 13'h1BFF;
               A_ESTAT:  r_estat_is_sw <= (r_estat_is_sw & w_wk[1:0]) | w_wd[1:0];
               A_ERA:    r_era <= (r_era & w_wk) | w_wd;
               A_BADV:   r_badv <= (r_badv & w_wk) | w_wd;
               A_EENTRY: r_eentry_va <= (r_eentry_va & w_wk[31:6]) | w_wd[31:6];
               A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                         r_save[w_addr[1:0]] <= (r_save[w_addr[1:0]] & w_wk) | w_wd;
               A_TID:    r_tid <= (r_tid & w_wk) | w_wd;
               A_TCFG:   r_tcfg <= w_tcfg_nv;
               A_TICLR:  if (w_wd[0]) r_estat_ti <= 1'b0;
               default:  ;
            endcase
         end

         // Timer sits after TICLR so a fire in the same cycle keeps IS[11] set.
         if (w_wr && (w_addr == A_TCFG) && w_tcfg_nv[0]) begin
            r_tval <= {w_tcfg_nv[31:2], 2'b00};
         end else if (r_tcfg[0]) begin
            if (r_tval != '0) begin
               r_tval <= r_tval - TIMER_W'(1);
            end else begin
               r_estat_ti <= 1'b1;
               if (r_tcfg[1]) r_tval <= {r_tcfg[31:2], 2'b00};
               else           r_tcfg[0] <= 1'b0;
            end
         end

         if (w_ex) begin
            r_prmd_pplv   <= r_crmd_plv;
            r_prmd_pie    <= r_crmd_ie;
            r_crmd_plv    <= '0;
            r_crmd_ie     <= 1'b0;
            r_estat_ecode <= w_ecode[5:0];
            r_estat_esub  <= {8'b0, w_esub};
            r_era         <= w_pc;
            if ((w_ecode == 8'h08) || (w_ecode == 8'h09)) r_badv <= w_vaddr;
         end else if (ertn_W) begin
            r_crmd_plv <= r_prmd_pplv;
            r_crmd_ie  <= r_prmd_pie;
         end
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         A_CRMD:   csr_rdata = w_crmd;
         A_PRMD:   csr_rdata = w_prmd;
         A_ECFG:   csr_rdata = w_ecfg;
         A_ESTAT:  csr_rdata = w_estat;
         A_ERA:    csr_rdata = r_era;
         A_BADV:   csr_rdata = r_badv;
         A_EENTRY: csr_rdata = w_eentry;
         A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                   csr_rdata = r_save[csr_raddr[1:0]];
         A_TID:    csr_rdata = r_tid;
         A_TCFG:   csr_rdata = r_tcfg;
         A_TVAL:   csr_rdata = r_tval;
         default:  csr_rdata = '0;
      endcase
   end

   assign ex_en    = w_ex | ertn_W;
   assign ex_entry = (ertn_W && !w_ex) ? r_era : w_eentry;
   assign has_int  = r_crmd_ie & (|(w_estat[12:0] & w_ecfg[12:0]));

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed walk through the main behaviours, then random traffic against a word-level model.
module tb_csr_file;
   logic         clk = 1'b0;
   logic         rstn;
   logic [152:0] bus;
   logic         ertn;
   logic [7:0]   hw;
   logic [13:0]  raddr;
   logic [31:0]  rdata, entry;
   logic         exen, irq_pend;

   always #5 clk = ~clk;

   csr_file #(.TIMER_W(32)) dut (
      .clk(clk), .rstn(rstn), .Wcsr_BUS(bus), .ertn_W(ertn), .hw_int(hw),
      .csr_raddr(raddr), .csr_rdata(rdata), .ex_en(exen), .ex_entry(entry), .has_int(irq_pend)
   );

   typedef struct {
      logic [13:0] a;
      logic [31:0] rd;
      logic        en;
      logic [31:0] ent;
      logic        hi;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic        s_ex, s_esub, s_we, s_ertn;
   logic [7:0]  s_ecode, s_hw;
   logic [13:0] s_addr, s_raddr;
   logic [31:0] s_wmask, s_wdata, s_pc, s_vaddr;

   logic [31:0] mr [int];
   logic [31:0] mtval;
   int impl  [13] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0C, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41};
   int alist [17] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0C, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41,
                      'h42, 'h44, 'h0A, 'h2000};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] wm(input int a);
      case (a)
         'h00: return 32'h0000_000F;
         'h01: return 32'h0000_0007;
         'h04: return 32'h0000_1BFF;
         'h05: return 32'h0000_0003;
         'h06, 'h07, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41: return 32'hFFFF_FFFF;
         'h0C: return 32'hFFFF_FFC0;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rd_of(input int a);
      if (a == 'h42) return mtval;
      if (mr.exists(a)) return mr[a];
      return 32'h0;
   endfunction

   function automatic void mreset();
      mr.delete();
      foreach (impl[i]) mr[impl[i]] = 32'h0;
      mr[0] = 32'h8;
      mtval = 32'h0;
   endfunction

   // Next-state of the whole CSR space for one retiring cycle described by s_*.
   function automatic void mstep();
      logic [31:0] o0, o1, ocfg, t, m, nt;
      bit tic, fire;
      int a;
      o0 = rd_of(0); o1 = rd_of(1); ocfg = rd_of('h41);
      nt = mtval; tic = 0; fire = 0; a = int'(s_addr);
      if (s_we && !s_ex) begin
         if (a == 'h44) tic = s_wdata[0] & s_wmask[0];
         else if (wm(a) != 0) begin
            m = s_wmask & wm(a);
            mr[a] = (mr[a] & ~m) | (s_wdata & m);
         end
      end
      if (s_ex) begin
         mr[1] = o0 & 32'h7;
         mr[0] = o0 & ~32'h7;
         t = mr[5];
         mr[5] = (t & 32'h0000_FFFF) | (32'(s_ecode[5:0]) << 16) | (32'(s_esub) << 22);
         mr[6] = s_pc;
         if (s_ecode == 8'h08 || s_ecode == 8'h09) mr[7] = s_vaddr;
      end else if (s_ertn) begin
         mr[0] = (mr[0] & ~32'h7) | (o1 & 32'h7);
      end
      t = mr[5];
      t = (t & ~32'h0000_03FC) | (32'(s_hw) << 2);
      m = mr['h41];
      if (s_we && !s_ex && a == 'h41 && m[0]) nt = m & ~32'h3;
      else if (ocfg[0]) begin
         if (mtval != 0) nt = mtval - 32'd1;
         else begin
            fire = 1;
            if (ocfg[1]) nt = ocfg & ~32'h3;
            else mr['h41] = m & ~32'h1;
         end
      end
      if (fire) t = t | 32'h800;
      else if (tic) t = t & ~32'h800;
      mr[5] = t;
      mtval = nt;
   endfunction

   task automatic idle();
      s_ex = 0; s_ecode = 0; s_esub = 0; s_we = 0; s_addr = 0; s_wmask = 0;
      s_wdata = 0; s_pc = 0; s_vaddr = 0; s_ertn = 0; s_hw = 0;
   endtask

   task automatic step();
      exp_t e;
      logic [31:0] c0, c4, c5;
      @(posedge clk); #1;
      bus   = {s_ex, s_ecode, s_esub, s_we, s_addr, s_wmask, s_wdata, s_pc, s_vaddr};
      ertn  = s_ertn;
      hw    = s_hw;
      raddr = s_raddr;
      c0 = rd_of(0); c4 = rd_of(4); c5 = rd_of(5);
      e.a   = s_raddr;
      e.rd  = rd_of(int'(s_raddr));
      e.en  = s_ex | s_ertn;
      e.ent = s_ex ? rd_of('hC) : rd_of(6);
      e.hi  = c0[2] & (|(c4[12:0] & c5[12:0]));
      sb.push_back(e);
      mstep();
   endtask

   task automatic rand_stim();
      int r;
      idle();
      s_ex    = ($urandom_range(0, 15) == 0);
      r       = int'($urandom_range(0, 3));
      s_ecode = (r == 0) ? 8'h08 : (r == 1) ? 8'h09 : 8'($urandom);
      s_esub  = 1'($urandom_range(0, 1));
      s_pc    = $urandom;
      s_vaddr = $urandom;
      s_ertn  = ($urandom_range(0, 11) == 0);
      s_hw    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      s_we    = ($urandom_range(0, 2) == 0);
      s_addr  = 14'(alist[$urandom_range(0, 16)]);
      s_wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      s_wdata = $urandom;
      if (s_addr == 14'h41) begin
         s_wdata = $urandom_range(0, 31);
         s_wmask = 32'hFFFF_FFFF;
      end
      s_raddr = 14'(alist[$urandom_range(0, 16)]);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("rdata[%0h]", e.a), rdata, e.rd);
            chk("ex_en", 32'(exen), 32'(e.en));
            if (e.en) chk("ex_entry", entry, e.ent);
            chk("has_int", 32'(irq_pend), 32'(e.hi));
         end
      end
   end

   initial begin
      int guard;
      rstn = 1'b0; bus = '0; ertn = 1'b0; hw = '0; raddr = '0;
      idle(); s_raddr = 0; mreset();
      #12;
      chk("rst_crmd", rdata, 32'h8);
      raddr = 14'h05; #1;
      chk("rst_estat", rdata, 32'h0);
      chk("rst_has_int", 32'(irq_pend), 32'h0);
      @(negedge clk); #1 rstn = 1'b1;

      idle(); s_we = 1; s_addr = 14'h00; s_wdata = 32'h7; s_wmask = 32'h4; s_raddr = 14'h00; step();
      idle(); step(); @(negedge clk); chk("crmd_masked", rdata, 32'hC);
      idle(); s_we = 1; s_addr = 14'h0C; s_wdata = 32'h1C00_8000; s_wmask = 32'hFFFF_FFFF; step();
      idle(); s_ex = 1; s_ecode = 8'h09; s_pc = 32'h1C00_0100; s_vaddr = 32'h1234_5677; step();
      @(negedge clk);
      chk("ex_en_same_cycle", 32'(exen), 32'h1);
      chk("ex_entry_eentry", entry, 32'h1C00_8000);
      idle(); s_raddr = 14'h06; step(); @(negedge clk); chk("era", rdata, 32'h1C00_0100);
      idle(); s_raddr = 14'h07; step(); @(negedge clk); chk("badv", rdata, 32'h1234_5677);
      idle(); s_raddr = 14'h05; step(); @(negedge clk); chk("estat_ecode", rdata, 32'h0009_0000);
      idle(); s_raddr = 14'h01; step(); @(negedge clk); chk("prmd", rdata, 32'h4);
      idle(); s_raddr = 14'h00; step(); @(negedge clk); chk("crmd_after_ex", rdata, 32'h8);

      idle(); s_ertn = 1; s_raddr = 14'h00; step(); @(negedge clk); chk("ex_entry_era", entry, 32'h1C00_0100);
      idle(); step(); @(negedge clk); chk("crmd_after_ertn", rdata, 32'hC);

      idle(); s_we = 1; s_addr = 14'h04; s_wdata = 32'h800; s_wmask = 32'hFFFF_FFFF; step();
      idle(); s_we = 1; s_addr = 14'h41; s_wdata = 32'h13; s_wmask = 32'hFFFF_FFFF; s_raddr = 14'h42; step();
      for (int k = 1; k <= 17; k++) begin
         idle(); s_raddr = 14'h42; step(); @(negedge clk);
         chk($sformatf("tval_k%0d", k), rdata, 32'(17 - k));
      end
      chk("no_int_before_fire", 32'(irq_pend), 32'h0);
      idle(); s_raddr = 14'h42; step(); @(negedge clk);
      chk("tval_reload", rdata, 32'h10);
      chk("has_int_timer", 32'(irq_pend), 32'h1);
      idle(); s_raddr = 14'h05; step(); @(negedge clk); chk("estat_ti_set", 32'(rdata[11]), 32'h1);
      idle(); s_we = 1; s_addr = 14'h44; s_wdata = 32'h1; s_wmask = 32'h1; s_raddr = 14'h05; step();
      idle(); s_raddr = 14'h05; step(); @(negedge clk);
      chk("ticlr_clears", 32'(rdata[11]), 32'h0);
      chk("ticlr_no_int", 32'(irq_pend), 32'h0);

      idle(); s_we = 1; s_addr = 14'h30; s_wdata = 32'hA5A5_0001; s_wmask = 32'hFFFF_FFFF; step();
      idle(); s_ex = 1; s_ecode = 8'h0B; s_pc = 32'h1C00_0200; s_vaddr = 32'hFFFF_0000;
      s_we = 1; s_addr = 14'h30; s_wdata = 32'hDEAD_BEEF; s_wmask = 32'hFFFF_FFFF; step();
      idle(); s_raddr = 14'h30; step(); @(negedge clk); chk("save0_kept", rdata, 32'hA5A5_0001);
      idle(); s_raddr = 14'h07; step(); @(negedge clk); chk("badv_kept", rdata, 32'h1234_5677);

      idle(); s_raddr = 14'h42; guard = 0;
      while (mtval != 0 && guard < 64) begin
         step();
         guard++;
      end
      if (mtval != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL timer_wait: tval never reached 0 within %0d cycles", guard);
      end
      idle(); s_we = 1; s_addr = 14'h44; s_wdata = 32'h1; s_wmask = 32'h1; s_raddr = 14'h42; step();
      @(negedge clk); chk("tval_zero_at_fire", rdata, 32'h0);
      idle(); s_raddr = 14'h05; step(); @(negedge clk); chk("fire_beats_ticlr", 32'(rdata[11]), 32'h1);

      idle(); s_raddr = 14'h42; step(); step(); @(negedge clk);
      bus = '0; ertn = 1'b0; hw = '0;
      #1 rstn = 1'b0;
      raddr = 14'h42; #1 chk("async_rst_tval", rdata, 32'h0);
      raddr = 14'h41; #1 chk("async_rst_tcfg", rdata, 32'h0);
      raddr = 14'h05; #1 chk("async_rst_estat", rdata, 32'h0);
      chk("async_rst_has_int", 32'(irq_pend), 32'h0);
      mreset();
      idle();
      @(negedge clk); #1 rstn = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         rand_stim();
         step();
      end
      @(negedge clk); #1;
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
